// File: rtl/uart_rx_sampler_if.sv
// Holding-register side of the UART receive sampler: received word, status flags and
// the consumer's ready/clear controls.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dout;
    logic                 dout_vld;
    logic                 dout_rdy;
    logic                 par_err;
    logic                 frm_err;
    logic                 ovr_err;
    logic                 err_clr;

    modport master (
        output dout, dout_vld, par_err, frm_err, ovr_err,
        input  dout_rdy, err_clr
    );

    modport slave (
        input  dout, dout_vld, par_err, frm_err, ovr_err,
        output dout_rdy, err_clr
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: after the start detector fires, times data/parity/stop bits on the
// 16x oversample tick, votes three samples per bit and holds the word in a valid/ready register.
module uart_rx_sampler #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        fr_div,
    input  logic              rxd,
    input  logic              process,
    output logic              vld_rx,
    output logic              busy,
    uart_rx_sampler_if.master out_if
);
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

    localparam logic       PAR_ODD = (PARITY == 1);
    localparam logic [2:0] LAST_BI = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic                 fr_nz_q, fr_nz_d;
    logic                 proc_q, proc_d;
    logic [3:0]           ph_q, ph_d;
    logic                 armed_q, armed_d;
    logic [2:0]           bi_q, bi_d;
    logic                 vld_rx_q, vld_rx_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shf_q, shf_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 ovr_err_q, ovr_err_d;

    logic tick, rise, decide, bit_v, load, accept;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign tick = (fr_div == 4'd0) && fr_nz_q;
    assign rise = process && !proc_q;

    always_comb begin
        state_d = state_q;
        fr_nz_d = (fr_div != 4'd0);
        proc_d  = process;
        ph_d    = ph_q;
        smp_d   = smp_q;
        armed_d = armed_q;
        bi_d    = bi_q;
        shf_d   = shf_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        if (state_q == S_IDLE) begin
            if (rise) ph_d = 4'd0;
        end else if (tick) begin
            ph_d = ph_q + 4'd1;
        end

        // armed marks that the ph==15 sample of the current bit exists, so the ph==1 tick
        // shortly after the start edge is not mistaken for a decision point
        if (state_q != S_IDLE && tick) begin
            if (ph_d == 4'd15) begin
                smp_d[0] = rxd;
                armed_d  = 1'b1;
            end
            if (ph_d == 4'd0) smp_d[1] = rxd;
        end

        decide = tick && armed_q && (ph_d == 4'd1);
        bit_v  = maj3(smp_q[0], smp_q[1], rxd);
        if (decide) armed_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_DATA;
                    bi_d    = 3'd0;
                    armed_d = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shf_d = {bit_v, shf_q[DATA_BITS-1:1]};
                    if (bi_q == LAST_BI) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                 bi_d = bi_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (decide) begin
                    perr_d  = ((^shf_q) ^ bit_v) != PAR_ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_d  = ~bit_v;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        vld_rx_d = (state_d == S_DONE);
    end

    always_comb begin
        load       = (state_q == S_DONE);
        accept     = dout_vld_q && out_if.dout_rdy;
        dout_d     = dout_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        dout_vld_d = dout_vld_q;
        ovr_err_d  = ovr_err_q;

        if (accept) dout_vld_d = 1'b0;
        if (out_if.err_clr) ovr_err_d = 1'b0;
        if (load) begin
            dout_d     = shf_q;
            par_err_d  = perr_q;
            frm_err_d  = ferr_q;
            dout_vld_d = 1'b1;
            if (dout_vld_q && !out_if.dout_rdy) ovr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fr_nz_q    <= 1'b0;
            proc_q     <= 1'b0;
            ph_q       <= 4'd0;
            armed_q    <= 1'b0;
            bi_q       <= 3'd0;
            vld_rx_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fr_nz_q    <= fr_nz_d;
            proc_q     <= proc_d;
            ph_q       <= ph_d;
            armed_q    <= armed_d;
            bi_q       <= bi_d;
            vld_rx_q   <= vld_rx_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        smp_q  <= smp_d;
        shf_q  <= shf_d;
        perr_q <= perr_d;
        ferr_q <= ferr_d;
    end

    assign vld_rx          = vld_rx_q;
    assign busy            = (state_q != S_IDLE);
    assign out_if.dout     = dout_q;
    assign out_if.dout_vld = dout_vld_q;
    assign out_if.par_err  = par_err_q;
    assign out_if.frm_err  = frm_err_q;
    assign out_if.ovr_err  = ovr_err_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: an 8N1 instance and an 8E1 instance driven with serial frames
// generated per oversample tick, checked against expected words, flags and frame timing.
module tb_uart_rx_sampler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] fr_div;
    logic       rxd;
    logic       proc_a, proc_b;
    logic       vld_rx_a, vld_rx_b;
    logic       busy_a, busy_b;

    uart_rx_sampler_if #(.DATA_BITS(8)) if_a ();
    uart_rx_sampler_if #(.DATA_BITS(8)) if_b ();

    uart_rx_sampler #(.DATA_BITS(8), .PARITY(0)) dut_a (
        .clk(clk), .rst(rst), .fr_div(fr_div), .rxd(rxd), .process(proc_a),
        .vld_rx(vld_rx_a), .busy(busy_a), .out_if(if_a.master)
    );

    uart_rx_sampler #(.DATA_BITS(8), .PARITY(2)) dut_b (
        .clk(clk), .rst(rst), .fr_div(fr_div), .rxd(rxd), .process(proc_b),
        .vld_rx(vld_rx_b), .busy(busy_b), .out_if(if_b.master)
    );

    int   n_tests, n_fail;
    int   p, z, tk, since_tick;
    bit   in_frame;
    logic exp_vld [2];
    logic exp_ovr [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; fr_div runs z zeros then 1..15, so exactly one tick per period at p==0.
    task automatic step();
        @(posedge clk);
        #1;
        p = (p + 1) % (z + 15);
        fr_div = (p < z) ? 4'd0 : 4'(p - z + 1);
        if (in_frame && p == 0) begin
            tk++;
            since_tick = 0;
        end else begin
            since_tick++;
        end
    endtask

    task automatic set_proc(input bit sel, input logic v);
        if (sel) proc_b = v; else proc_a = v;
    endtask

    task automatic set_rdy(input bit sel, input logic v);
        if (sel) if_b.dout_rdy = v; else if_a.dout_rdy = v;
    endtask

    task automatic set_clr(input bit sel, input logic v);
        if (sel) if_b.err_clr = v; else if_a.err_clr = v;
    endtask

    // Line level at tick t after the mid-start edge: bit k is centred on tick 16*(k+1).
    function automatic logic line_bit(input int t, input logic [7:0] d, input int npar,
                                      input logic pb, input logic sb);
        int idx;
        if (t < 8) return 1'b0;
        idx = (t + 8) / 16 - 1;
        if (idx < 8) return d[idx];
        if (idx < 8 + npar) return pb;
        if (idx == 8 + npar) return sb;
        return 1'b1;
    endfunction

    task automatic check_out(input bit sel, input logic [7:0] ed, input logic ep,
                             input logic ef, input logic ev, input logic eo);
        logic [7:0] d;
        logic pe, fe, v, o;
        d  = sel ? if_b.dout : if_a.dout;
        pe = sel ? if_b.par_err : if_a.par_err;
        fe = sel ? if_b.frm_err : if_a.frm_err;
        v  = sel ? if_b.dout_vld : if_a.dout_vld;
        o  = sel ? if_b.ovr_err : if_a.ovr_err;
        chk("dout", 32'(d), 32'(ed));
        chk("par_err", 32'(pe), 32'(ep));
        chk("frm_err", 32'(fe), 32'(ef));
        chk("dout_vld", 32'(v), 32'(ev));
        chk("ovr_err", 32'(o), 32'(eo));
    endtask

    task automatic check_zero(input bit sel);
        check_out(sel, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_vld_rx", 32'(sel ? vld_rx_b : vld_rx_a), 32'd0);
        chk("rst_busy", 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    // done_mode: 0 nothing, 1 dout_rdy during the load cycle, 2 err_clr during the load cycle.
    task automatic run_frame(input bit sel, input logic [7:0] data, input logic pbit,
                             input logic sbit, input int glitch_tk, input int rst_tk,
                             input int done_mode);
        int   npar, stop_tk, nvld, vld_tk, vld_since;
        bit   rst_pend, did_rst, busy_mid;
        logic v;
        npar      = sel ? 1 : 0;
        stop_tk   = 16 * (8 + npar + 1) + 1;
        nvld      = 0;
        vld_tk    = -1;
        vld_since = -1;
        rst_pend  = 1'b0;
        did_rst   = 1'b0;
        busy_mid  = 1'b0;
        step();
        z          = $urandom_range(1, 3);
        p          = z + 7;
        fr_div     = 4'd8;
        tk         = 0;
        since_tick = 0;
        in_frame   = 1'b1;
        rxd        = 1'b0;
        set_proc(sel, 1'b1);
        while (tk <= stop_tk + 4) begin
            step();
            if (nvld > 0) begin
                set_proc(sel, 1'b0);
                set_rdy(sel, 1'b0);
                set_clr(sel, 1'b0);
            end
            if (rst_pend) begin
                check_zero(sel);
                rst      = 1'b0;
                rst_pend = 1'b0;
            end
            v = sel ? vld_rx_b : vld_rx_a;
            if (v) begin
                nvld++;
                if (vld_tk < 0) begin
                    vld_tk    = tk;
                    vld_since = since_tick;
                    if (done_mode == 1) set_rdy(sel, 1'b1);
                    else if (done_mode == 2) set_clr(sel, 1'b1);
                end
            end
            if (tk == 80 && since_tick == 0) busy_mid = sel ? busy_b : busy_a;
            rxd = line_bit(tk, data, npar, pbit, sbit) ^ (tk == glitch_tk && since_tick == 0);
            if (!did_rst && rst_tk >= 0 && tk == rst_tk && since_tick == 0) begin
                rst      = 1'b1;
                set_proc(sel, 1'b0);
                rst_pend = 1'b1;
                did_rst  = 1'b1;
            end
        end
        in_frame = 1'b0;
        rxd      = 1'b1;
        set_proc(sel, 1'b0);
        if (rst_tk >= 0) begin
            chk("rst_no_vld_rx", 32'(nvld), 32'd0);
        end else begin
            chk("vld_rx_count", 32'(nvld), 32'd1);
            chk("vld_rx_tick", 32'(vld_tk), 32'(stop_tk));
            chk("vld_rx_latency", 32'(vld_since), 32'd1);
            chk("busy_mid", 32'(busy_mid), 32'd1);
            chk("busy_idle", 32'(sel ? busy_b : busy_a), 32'd0);
        end
    endtask

    task automatic frame_and_check(input bit sel, input logic [7:0] data, input logic pbit,
                                   input logic sbit, input int glitch_tk, input int done_mode);
        logic pe, fe;
        run_frame(sel, data, pbit, sbit, glitch_tk, -1, done_mode);
        pe = sel ? ((^data ^ pbit) != 1'b0) : 1'b0;
        fe = ~sbit;
        if (done_mode != 1 && exp_vld[sel]) exp_ovr[sel] = 1'b1;
        else if (done_mode == 2)            exp_ovr[sel] = 1'b0;
        exp_vld[sel] = 1'b1;
        check_out(sel, data, pe, fe, 1'b1, exp_ovr[sel]);
    endtask

    task automatic accept(input bit sel);
        set_rdy(sel, 1'b1);
        step();
        set_rdy(sel, 1'b0);
        exp_vld[sel] = 1'b0;
        chk("dout_vld_after_accept", 32'(sel ? if_b.dout_vld : if_a.dout_vld), 32'd0);
    endtask

    task automatic clear_err(input bit sel);
        set_clr(sel, 1'b1);
        step();
        set_clr(sel, 1'b0);
        exp_ovr[sel] = 1'b0;
        chk("ovr_err_after_clr", 32'(sel ? if_b.ovr_err : if_a.ovr_err), 32'd0);
        chk("dout_vld_after_clr", 32'(sel ? if_b.dout_vld : if_a.dout_vld), 32'(exp_vld[sel]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit         s;
        logic [7:0] d;
        logic       pb, sb;
        int         dm, g;
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        fr_div        = 4'd0;
        rxd           = 1'b1;
        proc_a        = 1'b0;
        proc_b        = 1'b0;
        if_a.dout_rdy = 1'b0;
        if_a.err_clr  = 1'b0;
        if_b.dout_rdy = 1'b0;
        if_b.err_clr  = 1'b0;
        z             = 1;
        p             = 0;
        tk            = 0;
        since_tick    = 0;
        in_frame      = 1'b0;
        exp_vld[0]    = 1'b0;
        exp_vld[1]    = 1'b0;
        exp_ovr[0]    = 1'b0;
        exp_ovr[1]    = 1'b0;

        repeat (3) step();
        check_zero(1'b0);
        check_zero(1'b1);
        rst = 1'b0;
        repeat (5) step();

        frame_and_check(1'b0, 8'hA5, 1'b0, 1'b1, -1, 0);
        repeat (20) step();
        check_out(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        accept(1'b0);

        frame_and_check(1'b1, 8'h03, 1'b1, 1'b1, -1, 0);
        accept(1'b1);
        frame_and_check(1'b1, 8'h03, 1'b0, 1'b1, -1, 0);
        accept(1'b1);

        frame_and_check(1'b0, 8'h55, 1'b0, 1'b0, -1, 0);
        accept(1'b0);

        frame_and_check(1'b0, 8'h00, 1'b0, 1'b1, 64, 0);
        accept(1'b0);

        frame_and_check(1'b0, 8'h11, 1'b0, 1'b1, -1, 0);
        frame_and_check(1'b0, 8'h22, 1'b0, 1'b1, -1, 0);
        clear_err(1'b0);
        frame_and_check(1'b0, 8'h33, 1'b0, 1'b1, -1, 2);

        run_frame(1'b0, 8'h99, 1'b0, 1'b1, -1, 60, 0);
        exp_vld[0] = 1'b0;
        exp_vld[1] = 1'b0;
        exp_ovr[0] = 1'b0;
        exp_ovr[1] = 1'b0;
        check_out(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        frame_and_check(1'b0, 8'h3C, 1'b0, 1'b1, -1, 0);
        accept(1'b0);

        for (int i = 0; i < 6; i++) begin
            s  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            dm = int'($urandom_range(0, 2));
            g  = -1;
            if ($urandom_range(0, 1) == 1)
                g = 16 * int'($urandom_range(1, 8)) + int'($urandom_range(0, 2)) - 1;
            frame_and_check(s, d, pb, sb, g, dm);
            if ($urandom_range(0, 1) == 1) accept(s);
            if ($urandom_range(0, 1) == 1) clear_err(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
